// File: rtl/hero_bus_arb_if.sv
// Hero write-bus arbiter interface: requester handshake plus the shared bus beats.
// The master modport is the arbiter side and the slave modport is the requester/sink side.
interface hero_bus_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = 36
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*HERO_WIDTH-1:0] req_wdat;
    logic [NUM_REQ-1:0]            req_ready;
    logic [3:0]                    hero_cycle_type;
    logic [HERO_WIDTH-1:0]         hero_wdat;
    logic                          hero_clk_en;
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    logic                          trunc_err;

    modport master (
        input  req_valid, req_last, req_wdat,
        output req_ready, hero_cycle_type, hero_wdat, hero_clk_en,
               grant_id, busy, trunc_err
    );

    modport slave (
        output req_valid, req_last, req_wdat,
        input  req_ready, hero_cycle_type, hero_wdat, hero_clk_en,
               grant_id, busy, trunc_err
    );
endinterface

// File: rtl/hero_bus_arb.sv
// Round-robin arbiter sharing one hero write bus among NUM_REQ requesters.
// A grant covers a whole transaction: VALID beats followed by one DONE beat,
// with transactions cut at MAX_BEATS (trunc_err pulses with the forced DONE).
// Bus outputs are registered, so a beat accepted in cycle N is driven in N+1.
// Optional feature: define HERO_ARB_STATS_EN to add the 16-bit txn_cnt output,
// which counts every DONE beat driven (truncations included) and wraps.
module hero_bus_arb #(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = 36,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hero_bus_arb_if.master        bus
`ifdef HERO_ARB_STATS_EN
    ,
    output logic [15:0]           txn_cnt
`endif
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);

    localparam logic [3:0] CT_IDLE  = 4'd0;
    localparam logic [3:0] CT_VALID = 4'd1;
    localparam logic [3:0] CT_DONE  = 4'd2;

    typedef enum logic {ARB, BURST} state_t;

    state_t                state;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         grant;
    logic [CW-1:0]         beat_cnt;
    logic [3:0]            cycle_type_q;
    logic [HERO_WIDTH-1:0] wdat_q;
    logic                  clk_en_q;
    logic                  trunc_q;

    logic [GW:0]           pick;
    logic [GW-1:0]         sel;
    logic                  acc;
    logic                  sel_last;
    logic [HERO_WIDTH-1:0] sel_wdat;
    logic                  at_limit;
    logic                  end_txn;
    logic [NUM_REQ-1:0]    ready;

    // Round-robin search starting just after ptr; returns {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0] ptr);
        logic          found;
        logic [GW-1:0] idx;
        logic [GW-1:0] cand;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k    = (int'(ptr) + i) % NUM_REQ;
            cand = GW'(k);
            if (!found && v[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Select the requester whose beat is accepted this cycle and mux its beat.
    always_comb begin
        pick     = rr_pick(bus.req_valid, rr_ptr);
        sel      = (state == ARB) ? pick[GW-1:0] : grant;
        acc      = (state == ARB) ? pick[GW] : bus.req_valid[grant];
        sel_last = 1'b0;
        sel_wdat = '0;
        ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == GW'(i)) begin
                sel_last = bus.req_last[i];
                sel_wdat = bus.req_wdat[i*HERO_WIDTH +: HERO_WIDTH];
                ready[i] = acc;
            end
        end
        at_limit = (state == BURST) && (beat_cnt == CW'(MAX_BEATS - 1));
        end_txn  = sel_last || at_limit;
    end

    assign bus.req_ready       = ready;
    assign bus.hero_cycle_type = cycle_type_q;
    assign bus.hero_wdat       = wdat_q;
    assign bus.hero_clk_en     = clk_en_q;
    assign bus.grant_id        = grant;
    assign bus.busy            = (state == BURST);
    assign bus.trunc_err       = trunc_q;

    // Arbitration FSM and registered bus beat; reset aborts any burst silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB;
            rr_ptr       <= GW'(NUM_REQ - 1);
            grant        <= '0;
            beat_cnt     <= '0;
            cycle_type_q <= CT_IDLE;
            wdat_q       <= '0;
            clk_en_q     <= 1'b0;
            trunc_q      <= 1'b0;
`ifdef HERO_ARB_STATS_EN
            txn_cnt      <= '0;
`endif
        end else begin
            trunc_q <= 1'b0;
            if (acc) begin
                grant    <= sel;
                wdat_q   <= sel_wdat;
                clk_en_q <= 1'b1;
                if (end_txn) begin
                    cycle_type_q <= CT_DONE;
                    trunc_q      <= !sel_last;
                    rr_ptr       <= sel;
                    beat_cnt     <= '0;
                    state        <= ARB;
`ifdef HERO_ARB_STATS_EN
                    txn_cnt      <= txn_cnt + 16'd1;
`endif
                end else begin
                    cycle_type_q <= CT_VALID;
                    beat_cnt     <= beat_cnt + CW'(1);
                    state        <= BURST;
                end
            end else begin
                cycle_type_q <= CT_IDLE;
                wdat_q       <= '0;
                clk_en_q     <= 1'b0;
            end
        end
    end
endmodule
